// File: rtl/ex_div_sequencer.sv
// EX-stage sequencer for RV32M DIV/DIVU/REM/REMU: one restoring iteration per cycle,
// stalls the pipeline while busy and presents the sign-corrected result in DONE.
module ex_div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            ex_flush,
  input  logic            pipe_hold,
  output logic            div_stall,
  output logic            div_done,
  output logic [XLEN-1:0] div_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q, neg_rem_q, sel_rem_q;

  logic            is_signed, dvd_neg, dvs_neg, div_zero, overflow, special, start;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic [XLEN:0]   shifted, trial;
  logic            fits;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_signed = ~div_opcode[0];
  assign dvd_neg   = is_signed & dividend[XLEN-1];
  assign dvs_neg   = is_signed & divisor[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dividend : dividend;
  assign dvs_abs   = dvs_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
  assign special   = div_zero | overflow;
  assign start     = div_req & ~ex_flush;

  // Partial remainder carries one extra bit so divisors >= 2^(XLEN-1) still compare correctly;
  // the top bit of the difference is the borrow.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign fits    = ~trial[XLEN];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    if (!pipe_hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ex_flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Special cases store their final values directly with the fixup flags cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem_q <= div_opcode[1];
            if (special) begin
              quo_q     <= div_zero ? '1 : dividend;
              rem_q     <= div_zero ? dividend : '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              quo_q     <= dvd_abs;
              rem_q     <= '0;
              dvs_q     <= dvs_abs;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              cnt_q     <= CNT_W'(XLEN-1);
            end
          end
        end
        CALC: begin
          rem_q <= fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], fits};
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  assign div_stall  = div_req & (state != DONE) & ~ex_flush;
  assign div_done   = (state == DONE);
  assign div_result = (state == DONE) ? (sel_rem_q ? rem_fix : quo_fix) : '0;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Self-checking bench for ex_div_sequencer: directed and random divides checked
// against a plain-arithmetic RV32M reference, plus flush, hold, back-to-back and reset.
module tb_ex_div_sequencer;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic            clk = 1'b0;
  logic            rst;
  logic            div_req;
  logic [1:0]      div_opcode;
  logic [XLEN-1:0] dividend, divisor;
  logic            ex_flush, pipe_hold;
  logic            div_stall, div_done;
  logic [XLEN-1:0] div_result;

  int tests  = 0;
  int failed = 0;

  ex_div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_opcode(div_opcode),
    .dividend(dividend), .divisor(divisor), .ex_flush(ex_flush), .pipe_hold(pipe_hold),
    .div_stall(div_stall), .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      OP_DIV:  return sa / sb;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Holds one instruction in EX until div_done; returns at negedge+1 of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stall_cnt, output int done_cyc, output logic [31:0] res);
    stall_cnt = 0;
    done_cyc  = -1;
    res       = 32'h0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      div_req = 1'b1; div_opcode = op; dividend = a; divisor = b;
      ex_flush = 1'b0; pipe_hold = 1'b0;
      #1;
      if (div_done) begin
        done_cyc = c;
        res      = div_result;
        break;
      end
      if (div_stall) stall_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; div_req = 1'b0; div_opcode = 2'd0; dividend = '0; divisor = '0;
    ex_flush = 1'b0; pipe_hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (div_stall !== 1'b0) begin failed++; $display("[TB] FAIL reset_stall got=%b exp=0", div_stall); end
    tests++;
    if (div_done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done got=%b exp=0", div_done); end
    tests++;
    if (div_result !== 32'h0) begin failed++; $display("[TB] FAIL reset_result got=%h exp=0", div_result); end
    rst = 1'b0;
  endtask

  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;

  task automatic test_directed();
    vec_t v[$];
    int st, dc, lat;
    logic [31:0] res;
    v.push_back('{OP_DIVU, 32'd100, 32'd7, 32'd14});
    v.push_back('{OP_REMU, 32'd100, 32'd7, 32'd2});
    v.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    v.push_back('{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    v.push_back('{OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    v.push_back('{OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1});
    v.push_back('{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF});
    v.push_back('{OP_REMU, 32'd5, 32'd0, 32'd5});
    v.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, st, dc, res);
      lat = ref_latency(v[i].op, v[i].a, v[i].b);
      tests++;
      if (res !== v[i].exp) begin
        failed++; $display("[TB] FAIL directed_result[%0d] got=%h exp=%h", i, res, v[i].exp);
      end
      tests++;
      if (dc != lat) begin
        failed++; $display("[TB] FAIL directed_done_cycle[%0d] got=%0d exp=%0d", i, dc, lat);
      end
      tests++;
      if (st != lat) begin
        failed++; $display("[TB] FAIL directed_stall_cycles[%0d] got=%0d exp=%0d", i, st, lat);
      end
    end
  endtask

  task automatic test_random();
    int st, dc;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, st, dc, res);
      tests++;
      if (res !== ref_div(op, a, b)) begin
        failed++;
        $display("[TB] FAIL random_result[%0d] op=%0d a=%h b=%h got=%h exp=%h",
                 i, op, a, b, res, ref_div(op, a, b));
      end
      tests++;
      if (dc != ref_latency(op, a, b)) begin
        failed++; $display("[TB] FAIL random_done_cycle[%0d] got=%0d exp=%0d", i, dc, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_flush();
    int st, dc;
    logic [31:0] res;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      div_req = 1'b1; div_opcode = OP_DIVU; dividend = 32'd12345; divisor = 32'd17;
      ex_flush = (c == 10); pipe_hold = 1'b0;
    end
    #1;
    tests++;
    if (div_stall !== 1'b0) begin failed++; $display("[TB] FAIL flush_stall got=%b exp=0", div_stall); end
    tests++;
    if (div_done !== 1'b0) begin failed++; $display("[TB] FAIL flush_done got=%b exp=0", div_done); end
    run_op(OP_DIVU, 32'd9, 32'd3, st, dc, res);
    tests++;
    if (res !== 32'd3) begin failed++; $display("[TB] FAIL flush_next_result got=%h exp=3", res); end
    tests++;
    if (dc != XLEN + 1) begin failed++; $display("[TB] FAIL flush_next_done_cycle got=%0d exp=%0d", dc, XLEN + 1); end
    tests++;
    if (st != XLEN + 1) begin failed++; $display("[TB] FAIL flush_next_stall_cycles got=%0d exp=%0d", st, XLEN + 1); end
  endtask

  task automatic test_hold();
    int st, dc;
    logic [31:0] a, b, res, exp;
    a   = $urandom;
    b   = $urandom_range(2, 1000);
    exp = ref_div(OP_DIV, a, b);
    run_op(OP_DIV, a, b, st, dc, res);
    pipe_hold = 1'b1;
    tests++;
    if (res !== exp) begin failed++; $display("[TB] FAIL hold_first_result got=%h exp=%h", res, exp); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      pipe_hold = (k < 3);
      #1;
      tests++;
      if (div_done !== 1'b1) begin failed++; $display("[TB] FAIL hold_done[%0d] got=%b exp=1", k, div_done); end
      tests++;
      if (div_result !== exp) begin
        failed++; $display("[TB] FAIL hold_result[%0d] got=%h exp=%h", k, div_result, exp);
      end
    end
    @(negedge clk);
    div_req = 1'b0; pipe_hold = 1'b0;
    #1;
    tests++;
    if (div_done !== 1'b0) begin failed++; $display("[TB] FAIL hold_release_done got=%b exp=0", div_done); end
  endtask

  task automatic test_back_to_back();
    int st, dc;
    logic [31:0] res;
    run_op(OP_DIVU, 32'd10, 32'd3, st, dc, res);
    tests++;
    if (res !== 32'd3) begin failed++; $display("[TB] FAIL b2b_first_result got=%h exp=3", res); end
    tests++;
    if (div_stall !== 1'b0) begin failed++; $display("[TB] FAIL b2b_stall_in_done got=%b exp=0", div_stall); end
    run_op(OP_REMU, 32'd10, 32'd3, st, dc, res);
    tests++;
    if (res !== 32'd1) begin failed++; $display("[TB] FAIL b2b_second_result got=%h exp=1", res); end
    tests++;
    if (dc != XLEN + 1) begin failed++; $display("[TB] FAIL b2b_second_done_cycle got=%0d exp=%0d", dc, XLEN + 1); end
  endtask

  task automatic test_reset_mid();
    int st, dc;
    logic [31:0] res;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      div_req = 1'b1; div_opcode = OP_DIVU; dividend = $urandom; divisor = 32'd3;
      ex_flush = 1'b0; pipe_hold = 1'b0;
    end
    #3;
    rst = 1'b1; div_req = 1'b0;
    #1;
    tests++;
    if (div_stall !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_stall got=%b exp=0", div_stall); end
    tests++;
    if (div_done !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_done got=%b exp=0", div_done); end
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_DIVU, 32'd8, 32'd2, st, dc, res);
    pipe_hold = 1'b1;
    tests++;
    if (res !== 32'd4) begin failed++; $display("[TB] FAIL rst_after_result got=%h exp=4", res); end
    tests++;
    if (dc != XLEN + 1) begin failed++; $display("[TB] FAIL rst_after_done_cycle got=%0d exp=%0d", dc, XLEN + 1); end
    // Asynchronous reset while parked in DONE must clear outputs before any clock edge.
    #2;
    rst = 1'b1; div_req = 1'b0;
    #1;
    tests++;
    if (div_done !== 1'b0) begin failed++; $display("[TB] FAIL rst_done_state_done got=%b exp=0", div_done); end
    tests++;
    if (div_result !== 32'h0) begin failed++; $display("[TB] FAIL rst_done_state_result got=%h exp=0", div_result); end
    @(negedge clk);
    rst = 1'b0; pipe_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
